// File: rtl/sm4_pkg.sv
// Shared definitions for the SM4 channel arbiter: FSM encoding and datapath widths.
package sm4_pkg;

    localparam int SM4_BLK_W = 128;
    localparam int SM4_KEY_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CFG,
        ST_WLO,
        ST_WHI,
        ST_XFER
    } sm4_state_e;

endpackage

// File: rtl/sm4_rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr, with wrap-around.
module sm4_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] j;

    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = '0;
        for (int i = 1; i <= N; i++) begin
            j = W'((int'(ptr) + i) % N);
            if (!any && req[j]) begin
                any = 1'b1;
                idx = j;
            end
        end
    end

endmodule

// File: rtl/sm4_ch_arbiter.sv
// Shares one SM4 AXIS engine between NCH channels, packet-granular round robin,
// reconfiguring the engine (after draining it) whenever channel or key changes.
module sm4_ch_arbiter
    import sm4_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CHW  = 2,
    parameter int OUTW = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NCH-1:0]           key_wr,
    input  logic [SM4_KEY_W-1:0]     key_in,
    input  logic                     sel_in,
    input  logic [NCH*SM4_BLK_W-1:0] s_tdata,
    input  logic [NCH-1:0]           s_tvalid,
    input  logic [NCH-1:0]           s_tlast,
    output logic [NCH-1:0]           s_tready,
    output logic                     core_cfg_vld,
    output logic [SM4_KEY_W-1:0]     core_key,
    output logic                     core_sel,
    output logic [SM4_BLK_W-1:0]     core_s_tdata,
    output logic                     core_s_tvalid,
    output logic                     core_s_tlast,
    input  logic                     core_s_tready,
    input  logic [SM4_BLK_W-1:0]     core_m_tdata,
    input  logic                     core_m_tvalid,
    input  logic                     core_m_tlast,
    output logic [SM4_BLK_W-1:0]     m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    output logic [CHW-1:0]           m_tdest,
    output logic                     busy
);

    sm4_state_e state, state_nxt;

    logic [CHW-1:0]                gnt, last_gnt, loaded_ch, pick_idx;
    logic                          pick_any, loaded_vld;
    logic [NCH-1:0]                kv, dirty, sel_tab, elig;
    logic [NCH-1:0][SM4_KEY_W-1:0] key_tab;
    logic [SM4_KEY_W-1:0]          key_hold;
    logic                          sel_hold;
    logic [OUTW-1:0]               outst;
    logic                          in_xfer, in_cfg, acc;

    assign elig = s_tvalid & kv;

    sm4_rr_pick #(.N(NCH), .W(CHW)) u_pick (
        .req (elig),
        .ptr (last_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign in_xfer = (state == ST_XFER);
    assign in_cfg  = (state == ST_CFG);

    assign core_s_tdata  = s_tdata[int'(gnt)*SM4_BLK_W +: SM4_BLK_W];
    assign core_s_tlast  = s_tlast[gnt];
    assign core_s_tvalid = in_xfer & s_tvalid[gnt];
    assign acc           = core_s_tvalid & core_s_tready;

    // Key is shown straight from the table during CFG so a same-cycle write is not lost:
    // the write re-marks the entry dirty and the next packet reconfigures again.
    assign core_cfg_vld = in_cfg;
    assign core_key     = in_cfg ? key_tab[gnt] : key_hold;
    assign core_sel     = in_cfg ? sel_tab[gnt] : sel_hold;

    always_comb begin
        s_tready = '0;
        if (in_xfer) s_tready[gnt] = core_s_tready;
    end

    assign m_tdata  = core_m_tdata;
    assign m_tvalid = core_m_tvalid;
    assign m_tlast  = core_m_tlast;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    if (loaded_vld && (pick_idx == loaded_ch) && !dirty[pick_idx])
                        state_nxt = ST_XFER;
                    else
                        state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: if (outst == '0) state_nxt = ST_CFG;
            ST_CFG:   state_nxt = ST_WLO;
            ST_WLO:   if (!core_s_tready) state_nxt = ST_WHI;
            ST_WHI:   if (core_s_tready) state_nxt = ST_XFER;
            ST_XFER:  if (acc && core_s_tlast) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            last_gnt   <= CHW'(NCH - 1);
            loaded_vld <= 1'b0;
            loaded_ch  <= '0;
            m_tdest    <= '0;
            key_hold   <= '0;
            sel_hold   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && pick_any) gnt <= pick_idx;
            if (in_cfg) begin
                key_hold   <= key_tab[gnt];
                sel_hold   <= sel_tab[gnt];
                loaded_vld <= 1'b0;
                loaded_ch  <= gnt;
                // pipeline is empty here, so retagging the output is safe
                m_tdest    <= gnt;
            end
            if (state == ST_WHI && core_s_tready) loaded_vld <= 1'b1;
            if (acc && core_s_tlast) last_gnt <= gnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outst <= '0;
        end else if (acc && !core_m_tvalid && outst != '1) begin
            outst <= outst + 1'b1;
        end else if (!acc && core_m_tvalid && outst != '0) begin
            outst <= outst - 1'b1;
        end
    end

    // A write wins over the CFG clear so a key landing mid-reconfig is never dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_tab <= '0;
            sel_tab <= '0;
            kv      <= '0;
            dirty   <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (in_cfg && gnt == CHW'(c)) dirty[c] <= 1'b0;
                if (key_wr[c]) begin
                    key_tab[c] <= key_in;
                    sel_tab[c] <= sel_in;
                    kv[c]      <= 1'b1;
                    dirty[c]   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm4_ch_arbiter.sv
// Bench for sm4_ch_arbiter: behavioural engine stand-in (invertible toy cipher, latency,
// reconfig stall), output scoreboard, grant-order table and multi-cycle corner sequences.
module tb_sm4_ch_arbiter;

    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int OUTW = 8;
    localparam int LAT = 3;
    localparam logic [127:0] KEY_A = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KEY_B = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT    = 128'h0123456789abcdeffedcba9876543210;

    logic               clk, reset_n;
    logic [NCH-1:0]     key_wr;
    logic [127:0]       key_in;
    logic               sel_in;
    logic [NCH*128-1:0] s_tdata;
    logic [NCH-1:0]     s_tvalid, s_tlast, s_tready;
    logic               core_cfg_vld, core_sel, core_s_tvalid, core_s_tlast, core_s_tready;
    logic [127:0]       core_key, core_s_tdata, core_m_tdata, m_tdata;
    logic               core_m_tvalid, core_m_tlast, m_tvalid, m_tlast, busy;
    logic [CHW-1:0]     m_tdest;

    sm4_ch_arbiter #(.NCH(NCH), .CHW(CHW), .OUTW(OUTW)) dut (
        .clk(clk), .reset_n(reset_n), .key_wr(key_wr), .key_in(key_in), .sel_in(sel_in),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .core_cfg_vld(core_cfg_vld), .core_key(core_key), .core_sel(core_sel),
        .core_s_tdata(core_s_tdata), .core_s_tvalid(core_s_tvalid), .core_s_tlast(core_s_tlast),
        .core_s_tready(core_s_tready), .core_m_tdata(core_m_tdata), .core_m_tvalid(core_m_tvalid),
        .core_m_tlast(core_m_tlast), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tdest(m_tdest), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // enc = rotl13(d) ^ k ; dec = rotr13(c ^ k)
    function automatic logic [127:0] cipher(input logic [127:0] k, input logic s, input logic [127:0] d);
        logic [127:0] t;
        if (!s) return {d[114:0], d[127:115]} ^ k;
        t = d ^ k;
        return {t[12:0], t[127:13]};
    endfunction

    // engine stand-in
    logic                eng_rdy;
    int                  rc_cnt;
    logic [127:0]        ek;
    logic                es;
    logic [LAT-1:0]      pv, pl;
    logic [LAT-1:0][127:0] pd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_rdy <= 1'b1; rc_cnt <= 0; ek <= '0; es <= 1'b0; pv <= '0; pl <= '0; pd <= '0;
        end else begin
            if (core_cfg_vld) begin
                ek <= core_key; es <= core_sel; eng_rdy <= 1'b0; rc_cnt <= 4;
            end else if (rc_cnt > 0) begin
                rc_cnt <= rc_cnt - 1;
                if (rc_cnt == 1) eng_rdy <= 1'b1;
            end
            pv <= {pv[LAT-2:0], core_s_tvalid & eng_rdy};
            pl <= {pl[LAT-2:0], core_s_tlast};
            pd <= {pd[LAT-2:0], cipher(ek, es, core_s_tdata)};
        end
    end
    assign core_s_tready = eng_rdy;
    assign core_m_tvalid = pv[LAT-1];
    assign core_m_tlast  = pl[LAT-1];
    assign core_m_tdata  = pd[LAT-1];

    typedef struct packed {
        logic [127:0]   d;
        logic           l;
        logic [CHW-1:0] dest;
    } sb_t;

    sb_t          sb[$];
    int           gnt_log[$];
    int           acc_cyc[$];
    logic [127:0] exp_key[NCH];
    logic         exp_sel[NCH];
    int           cyc = 0;
    int           cfg_cnt = 0;
    logic         prev_cfg = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // accepted input beat -> expected result pushed
    always @(negedge clk) begin
        if (reset_n && core_s_tvalid && core_s_tready) begin
            int c;
            sb_t e;
            c = 0;
            for (int i = 0; i < NCH; i++) if (s_tready[i]) c = i;
            chk("tready_onehot", 128'($countones(s_tready)), 128'd1);
            e.d    = cipher(exp_key[c], exp_sel[c], s_tdata[c*128 +: 128]);
            e.l    = s_tlast[c];
            e.dest = CHW'(c);
            sb.push_back(e);
            gnt_log.push_back(c);
            acc_cyc.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (reset_n && m_tvalid) begin
            sb_t e;
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 128'd1, 128'd0);
            end else begin
                e = sb.pop_front();
                chk("m_tdata", m_tdata, e.d);
                chk("m_tlast", 128'(m_tlast), 128'(e.l));
                chk("m_tdest", 128'(m_tdest), 128'(e.dest));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && core_cfg_vld) begin
            cfg_cnt++;
            chk("cfg_engine_drained", 128'(pv), 128'd0);
            chk("cfg_pulse_width", 128'(prev_cfg), 128'd0);
        end
        prev_cfg = core_cfg_vld;
    end

    task automatic do_reset();
        reset_n = 1'b0;
        s_tvalid = '0; s_tlast = '0; key_wr = '0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete(); gnt_log.delete(); acc_cyc.delete();
        for (int c = 0; c < NCH; c++) begin exp_key[c] = '0; exp_sel[c] = 1'b0; end
        reset_n = 1'b1;
    endtask

    task automatic wr_key(input int c, input logic [127:0] k, input logic s, input bit upd);
        key_wr = '0; key_wr[c] = 1'b1; key_in = k; sel_in = s;
        @(posedge clk); #1;
        key_wr = '0;
        if (upd) begin exp_key[c] = k; exp_sel[c] = s; end
    endtask

    task automatic send(input int c, input int n, input logic [127:0] base, input bit pre);
        for (int b = 0; b < n; b++) begin
            logic [127:0] d;
            int t;
            d = base + 128'(b);
            if (pre) d = cipher(KEY_A, 1'b0, d);
            s_tdata[c*128 +: 128] = d;
            s_tlast[c] = (b == n - 1);
            s_tvalid[c] = 1'b1;
            t = 0;
            @(negedge clk);
            while (!s_tready[c] && t < 300) begin @(negedge clk); t++; end
            if (t >= 300) begin
                chk("send_timeout", 128'd1, 128'd0);
                s_tvalid[c] = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_tvalid[c] = 1'b0;
        s_tlast[c] = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || pv != '0) && t < 200) begin @(negedge clk); t++; end
        chk("drain_timeout", 128'(t >= 200), 128'd0);
        @(posedge clk); #1;
    endtask

    typedef struct packed {
        logic [NCH-1:0]      kv;
        logic [4:0][CHW-1:0] seq;
    } rr_vec_t;

    rr_vec_t tbl[3];

    initial begin
        int c0, i0, t;
        tbl[0] = '{kv: 4'hF, seq: {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[1] = '{kv: 4'hB, seq: {2'd1, 2'd0, 2'd3, 2'd1, 2'd0}};
        tbl[2] = '{kv: 4'h6, seq: {2'd1, 2'd2, 2'd1, 2'd2, 2'd1}};

        reset_n = 1'b0; key_wr = '0; key_in = '0; sel_in = 1'b0;
        s_tdata = '0; s_tvalid = '0; s_tlast = '0;
        #12;
        chk("rst_s_tready", 128'(s_tready), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_cfg_vld", 128'(core_cfg_vld), 128'd0);
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_core_sel", 128'(core_sel), 128'd0);
        chk("rst_m_tdest", 128'(m_tdest), 128'd0);
        do_reset();

        // request without a key is ignored
        s_tdata[127:0] = PT; s_tlast[0] = 1'b1; s_tvalid[0] = 1'b1;
        repeat (10) @(negedge clk);
        chk("nokey_busy", 128'(busy), 128'd0);
        chk("nokey_no_accept", 128'(gnt_log.size()), 128'd0);
        @(posedge clk); #1; s_tvalid = '0; s_tlast = '0;

        // single channel, one beat
        wr_key(0, KEY_A, 1'b0, 1'b1);
        c0 = cfg_cnt;
        send(0, 1, PT, 1'b0);
        wait_drain();
        chk("single_cfg_cnt", 128'(cfg_cnt - c0), 128'd1);
        chk("single_core_key", core_key, KEY_A);

        // back-to-back same channel, same key
        c0 = cfg_cnt; i0 = acc_cyc.size();
        send(0, 2, 128'h1000, 1'b0);
        send(0, 2, 128'h2000, 1'b0);
        wait_drain();
        chk("b2b_cfg_cnt", 128'(cfg_cnt - c0), 128'd0);
        if (acc_cyc.size() >= i0 + 4)
            chk("b2b_gap", 128'(acc_cyc[i0+2] - acc_cyc[i0+1]), 128'd2);
        else
            chk("b2b_beats", 128'(acc_cyc.size() - i0), 128'd4);

        // encrypt on ch0, decrypt on ch1 with the same key
        do_reset();
        wr_key(0, KEY_A, 1'b0, 1'b1);
        wr_key(1, KEY_A, 1'b1, 1'b1);
        c0 = cfg_cnt;
        fork
            send(0, 3, PT, 1'b0);
            send(1, 3, PT, 1'b1);
        join
        wait_drain();
        chk("xch_cfg_cnt", 128'(cfg_cnt - c0), 128'd2);
        chk("xch_n_beats", 128'(gnt_log.size()), 128'd6);
        if (gnt_log.size() >= 6) begin
            chk("xch_first", 128'(gnt_log[0]), 128'd0);
            chk("xch_second", 128'(gnt_log[3]), 128'd1);
        end

        // round-robin order table, continuous 1-beat packets
        for (int v = 0; v < 3; v++) begin
            do_reset();
            for (int c = 0; c < NCH; c++) if (tbl[v].kv[c]) wr_key(c, KEY_B, 1'b0, 1'b1);
            for (int c = 0; c < NCH; c++) s_tdata[c*128 +: 128] = PT + 128'(c);
            s_tlast = '1; s_tvalid = '1;
            t = 0;
            while (gnt_log.size() < 5 && t < 600) begin @(negedge clk); t++; end
            @(posedge clk); #1;
            s_tvalid = '0; s_tlast = '0;
            wait_drain();
            chk("rr_timeout", 128'(t >= 600), 128'd0);
            for (int k = 0; k < 5; k++)
                if (gnt_log.size() > k) chk($sformatf("rr_v%0d_g%0d", v, k), 128'(gnt_log[k]), 128'(tbl[v].seq[k]));
        end

        // key rewrite mid-packet: packet finishes with the old key
        do_reset();
        wr_key(0, KEY_A, 1'b0, 1'b1);
        fork
            send(0, 4, 128'h3000, 1'b0);
            begin
                t = 0;
                while (gnt_log.size() == 0 && t < 300) begin @(negedge clk); t++; end
                @(posedge clk); #1;
                wr_key(0, KEY_B, 1'b1, 1'b0);
            end
        join
        wait_drain();
        exp_key[0] = KEY_B; exp_sel[0] = 1'b1;
        c0 = cfg_cnt;
        send(0, 1, 128'h4000, 1'b0);
        wait_drain();
        chk("rekey_cfg_cnt", 128'(cfg_cnt - c0), 128'd1);
        chk("rekey_core_key", core_key, KEY_B);
        chk("rekey_core_sel", 128'(core_sel), 128'd1);

        // reset during XFER
        do_reset();
        wr_key(0, KEY_A, 1'b0, 1'b1);
        s_tdata[127:0] = PT; s_tlast[0] = 1'b0; s_tvalid[0] = 1'b1;
        t = 0;
        while (gnt_log.size() == 0 && t < 300) begin @(negedge clk); t++; end
        chk("mid_rst_reached_xfer", 128'(gnt_log.size() > 0), 128'd1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_tready", 128'(s_tready), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_core_tvalid", 128'(core_s_tvalid), 128'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        gnt_log.delete();
        c0 = cfg_cnt;
        repeat (30) @(negedge clk);
        chk("post_rst_no_grant", 128'(gnt_log.size()), 128'd0);
        chk("post_rst_busy", 128'(busy), 128'd0);
        chk("post_rst_no_cfg", 128'(cfg_cnt - c0), 128'd0);
        s_tvalid = '0; s_tlast = '0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sm4_ch_arbiter.md
Name: sm4_ch_arbiter

Overview:
- Shares one SM4 AXIS engine between NCH independent requester channels.
- The engine has a 128-bit data path, a `cfg_vld` / key / sel reconfiguration input, and no output backpressure.
- Each channel holds its own key and direction. The block round-robin-grants whole packets (`tlast`-delimited).
- On a channel or key change it drains the engine pipeline, reconfigures the engine, then streams the packet. Results are tagged with the owning channel on `m_axis_tdest`.

Parameters:
- NCH, 4, number of requester channels (2..8).
- CHW, 2, channel-id width; must be at least clog2(NCH).
- OUTW, 8, width of the in-flight beat counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset: one clock, asynchronous assertion, active-low.
- key_wr  in  NCH  one-hot key-table write strobe.
- key_in  in  128  key for the write.
- sel_in  in  1  direction for the write: 0 encrypt, 1 decrypt.
- s_tdata  in  NCH*128  per-channel input data; channel c uses bits [c*128 +: 128].
- s_tvalid  in  NCH  per-channel valid.
- s_tlast  in  NCH  per-channel last.
- s_tready  out  NCH  per-channel ready.
- core_cfg_vld  out  1  one-cycle engine reconfiguration pulse.
- core_key  out  128  key presented to the engine.
- core_sel  out  1  direction presented to the engine.
- core_s_tdata  out  128  data to the engine.
- core_s_tvalid  out  1  valid to the engine.
- core_s_tlast  out  1  last to the engine.
- core_s_tready  in  1  engine ready; low during reconfiguration.
- core_m_tdata  in  128  engine result data.
- core_m_tvalid  in  1  engine result valid.
- core_m_tlast  in  1  engine result last.
- m_tdata  out  128  result data.
- m_tvalid  out  1  result valid.
- m_tlast  out  1  result last.
- m_tdest  out  CHW  owning channel of the result.
- busy  out  1  asserted whenever state is not IDLE.

Behaviour:
- Reset values:
  - FSM is IDLE.
  - `core_cfg_vld`, `core_sel`, `s_tready`, `busy` are 0; `core_key` is 0.
  - Key table cleared; `kv[]` (key-valid) and `dirty[]` are 0.
  - `loaded_vld` is 0, `loaded_ch` is 0, `m_tdest` is 0, `outst` is 0.
  - Round-robin pointer `last_gnt` is NCH-1.
- Key table:
  - `key_wr[c]` writes `key_in`/`sel_in` to entry c and sets `kv[c]` and `dirty[c]`.
  - A write that lands during channel c's XFER is stored; the current packet keeps the old key.
- Eligibility: channel c is eligible when `s_tvalid[c]` and `kv[c]` are both 1. A channel with `kv` = 0 is never granted and its `s_tready` stays 0.
- IDLE:
  - Pick the first eligible channel scanning from `last_gnt`+1 with wrap-around, and register it as `gnt`.
  - If `loaded_vld` is 1, `gnt` equals `loaded_ch`, and `dirty[gnt]` is 0, go to XFER. Otherwise go to DRAIN.
  - With no eligible channel, stay in IDLE.
- DRAIN: wait until `outst` is 0, then go to CFG.
- CFG:
  - Drive `core_key` and `core_sel` from entry `gnt` (held until the next CFG).
  - Pulse `core_cfg_vld` for exactly 1 cycle.
  - Clear `loaded_vld` and `dirty[gnt]`. Set `loaded_ch` to `gnt`.
  - Go to WLO.
- WLO: wait until `core_s_tready` is 0, then go to WHI.
- WHI: wait until `core_s_tready` is 1, then set `loaded_vld` to 1 and go to XFER.
- XFER:
  - `s_tready[gnt]` equals `core_s_tready`; all other bits of `s_tready` are 0.
  - `core_s_*` is muxed combinationally from channel `gnt`; `core_s_tvalid` equals `s_tvalid[gnt]`.
  - A beat is accepted when `core_s_tvalid` and `core_s_tready` are both 1.
  - An accepted beat with `tlast` sets `last_gnt` to `gnt` and returns the FSM to IDLE.
  - `key_wr[gnt]` during XFER does not abort the packet.
- `core_s_tvalid` is 0 outside XFER.
- In-flight counter `outst`:
  - +1 on an accepted input beat.
  - -1 on `core_m_tvalid`.
  - Both in the same cycle: unchanged.
  - Saturating; never wraps.
- Output path:
  - `m_tdata`, `m_tvalid`, `m_tlast` are combinational pass-through of the engine outputs.
  - `m_tdest` is registered and updated to `loaded_ch` in CFG. This is valid because the pipeline is empty at every channel switch.
  - There is no output backpressure; downstream must always accept.
- Latency:
  - Same channel, clean key: first input beat accepted 1 cycle after grant.
  - Switch: drain time, plus 1 CFG cycle, plus the engine reconfiguration time.
- Reset mid-operation clears everything, including the key table. Packet data in flight is discarded by the host.

Decomposition:
- Shared sm4 package holds:
  - the FSM state encoding (IDLE, DRAIN, CFG, WLO, WHI, XFER);
  - localparams `SM4_BLK_W` = 128 and `SM4_KEY_W` = 128.
- One natural sub-module, `sm4_rr_pick`: combinational round-robin priority picker over NCH requests, with a start pointer, giving a grant index and an any-request flag.

Test Plan:
- Single channel: write ch0 key 0123456789abcdeffedcba9876543210 with sel 0, then send 1 beat of the same value with tlast → exactly one `core_cfg_vld` pulse; `m_tdata` = 681edf34d206965e86b3e94f536e4246, `m_tdest` = 0, `m_tlast` = 1.
- Back-to-back packets on ch0 with the same key → no second `core_cfg_vld`; second packet's beats are accepted immediately after the first packet's tlast.
- ch0 with sel 0 and ch1 (same key) with sel 1, both valid, each with a 3-beat packet → order ch0 then ch1; no ch1 beat is accepted before `outst` = 0; ch1 output equals the original plaintext with `m_tdest` = 1.
- All 4 channels continuously valid with 1-beat packets → grant sequence 0,1,2,3,0; ch2 with `kv` = 0 is skipped (sequence 0,1,3,0).
- `key_wr[0]` in the middle of a ch0 packet → packet completes under the old key; the next ch0 packet triggers DRAIN and CFG with the new key.
- Assert `reset_n` low during XFER → `s_tready` drops immediately, state is IDLE, `kv` is cleared; a later request without a key write is never granted.
